// File: rtl/sfr_framer.sv
// Serial frame receiver: hunts for a 4-bit sync word, then assembles BYTES_PER_FRAME
// bytes MSB-first into a one-deep output buffer. Define SFR_FRAMER_PARITY_EN for even parity.
module sfr_framer #(
    parameter logic [3:0] SYNC_WORD       = 4'hA,
    parameter int         BYTES_PER_FRAME = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_d,
    input  logic       i_en,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_locked,
    output logic       o_overflow,
    output logic       o_perr
);

    // state | meaning
    // HUNT  | shifting serial bits into the window, waiting for SYNC_WORD
    // DATA  | assembling frame bytes; o_locked high
    typedef enum logic {HUNT, DATA} state_t;

`ifdef SFR_FRAMER_PARITY_EN
    localparam int         SHW      = 8;
    localparam logic [3:0] BIT_LAST = 4'd8;
`else
    localparam int         SHW      = 7;
    localparam logic [3:0] BIT_LAST = 4'd7;
`endif
    localparam logic [7:0] BYTE_LAST = 8'(BYTES_PER_FRAME - 1);

    state_t           state, state_nxt;
    logic [3:0]       win;
    logic [3:0]       win_shift;
    logic [3:0]       bit_cnt;
    logic [7:0]       byte_cnt;
    logic [SHW-1:0]   shreg;
    logic [7:0]       byte_val;
    logic             perr_val;
    logic             byte_done;
    logic             frame_done;
    logic             drain;

    assign o_locked = (state == DATA);

    always_comb begin
        state_nxt  = state;
        win_shift  = {win[2:0], i_d};
        byte_done  = 1'b0;
        frame_done = 1'b0;
        drain      = o_valid && i_ready;
`ifdef SFR_FRAMER_PARITY_EN
        // the last captured bit is the parity bit; the data byte is already complete
        byte_val   = shreg;
        perr_val   = ^{shreg, i_d};
`else
        byte_val   = {shreg, i_d};
        perr_val   = 1'b0;
`endif
        case (state)
            HUNT: begin
                if (i_en && (win_shift == SYNC_WORD)) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (i_en && (bit_cnt == BIT_LAST)) begin
                    byte_done = 1'b1;
                    if (byte_cnt == BYTE_LAST) begin
                        frame_done = 1'b1;
                        state_nxt  = HUNT;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= HUNT;
            win      <= 4'h0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 8'd0;
            shreg    <= '0;
        end else begin
            state <= state_nxt;
            if (i_en) begin
                if (state == HUNT) begin
                    win      <= win_shift;
                    bit_cnt  <= 4'd0;
                    byte_cnt <= 8'd0;
                end else if (byte_done) begin
                    bit_cnt <= 4'd0;
                    if (frame_done) begin
                        // a new sync must be built from four fresh bits
                        win      <= 4'h0;
                        byte_cnt <= 8'd0;
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {shreg[SHW-2:0], i_d};
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data     <= 8'h00;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            o_perr     <= 1'b0;
        end else if (byte_done) begin
            if (!o_valid || i_ready) begin
                o_data  <= byte_val;
                o_perr  <= perr_val;
                o_valid <= 1'b1;
            end else begin
                o_overflow <= 1'b1;
            end
        end else if (drain) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sfr_framer.sv
// Bench for sfr_framer: directed frame scenarios plus randomized serial traffic,
// all compared against a bit-level behavioural model of the framer.
module tb_sfr_framer;

    localparam logic [3:0] SYNC = 4'hA;
    localparam int         BPF  = 4;
`ifdef SFR_FRAMER_PARITY_EN
    localparam int         NB   = 9;
`else
    localparam int         NB   = 8;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_d = 1'b0;
    logic       i_en = 1'b0;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_locked;
    logic       o_overflow;
    logic       o_perr;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    // reference model state
    int m_locked, m_win, m_nbits, m_acc, m_par, m_nbytes;
    int m_valid, m_data, m_ovf, m_perr;

    sfr_framer #(.SYNC_WORD(SYNC), .BYTES_PER_FRAME(BPF)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .i_en(i_en), .i_ready(i_ready),
        .o_data(o_data), .o_valid(o_valid), .o_locked(o_locked),
        .o_overflow(o_overflow), .o_perr(o_perr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_win = 0; m_nbits = 0; m_acc = 0; m_par = 0; m_nbytes = 0;
        m_valid = 0; m_data = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic model_step(input logic d, input logic en, input logic rdy);
        int drain;
        int done;
        int bval;
        int bperr;
        drain = (m_valid != 0 && rdy) ? 1 : 0;
        done  = 0;
        bval  = 0;
        bperr = 0;
        if (en) begin
            if (m_locked == 0) begin
                m_win = (m_win * 2 + int'(d)) % 16;
                if (m_win == int'(SYNC)) begin
                    m_locked = 1; m_nbits = 0; m_nbytes = 0; m_acc = 0;
                end
            end else begin
                m_nbits++;
                if (m_nbits <= 8) m_acc = (m_acc * 2 + int'(d)) % 256;
                else m_par = int'(d);
                if (m_nbits == NB) begin
                    done  = 1;
                    bval  = m_acc;
                    bperr = (NB == 9) ? ($countones(m_acc) + m_par) % 2 : 0;
                    m_nbits = 0;
                    m_acc = 0;
                    m_nbytes++;
                    if (m_nbytes == BPF) begin
                        m_locked = 0;
                        m_win = 0;
                    end
                end
            end
        end
        if (done != 0) begin
            if (m_valid == 0 || drain != 0) begin
                m_data = bval; m_perr = bperr; m_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (drain != 0) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("valid",    32'(o_valid),    32'(m_valid));
        check("locked",   32'(o_locked),   32'(m_locked));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("data",     32'(o_data),     32'(m_data));
        check("perr",     32'(o_perr),     32'(m_perr));
    endtask

    task automatic step(input logic d, input logic en, input logic rdy);
        @(negedge i_clk);
        i_d = d; i_en = en; i_ready = rdy;
        model_step(d, en, rdy);
        @(posedge i_clk);
        #1;
        if (o_valid) pulses++;
        compare_all();
    endtask

    // asserts reset at the current time, checks outputs clear at once, releases on a falling edge
    task automatic do_reset();
        i_rst = 1'b1; i_en = 1'b0; i_ready = 1'b0;
        model_reset();
        #1;
        check("rst_valid",    32'(o_valid),    32'd0);
        check("rst_locked",   32'(o_locked),   32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_data",     32'(o_data),     32'd0);
        check("rst_perr",     32'(o_perr),     32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        pulses = 0;
    endtask

    task automatic send_sync(input logic rdy);
        logic [3:0] s;
        s = SYNC;
        for (int i = 3; i >= 0; i--) step(s[i], 1'b1, rdy);
    endtask

    // bad=1 sends an inverted (odd) parity bit when parity is enabled
    task automatic send_byte(input logic [7:0] b, input logic rdy, input logic bad);
        for (int i = 7; i >= 0; i--) step(b[i], 1'b1, rdy);
        if (NB == 9) step((^b) ^ bad, 1'b1, rdy);
    endtask

    initial begin
        logic [7:0] c3;
        logic [7:0] bytes4 [4];
        c3 = 8'hC3;
        bytes4 = '{8'h01, 8'h02, 8'h03, 8'h04};
        model_reset();
        #2;
        do_reset();

        // single byte after sync, window starts from a leading 0
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("pre_lock", 32'(o_locked), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("lock_after_5", 32'(o_locked), 32'd1);
        send_byte(c3, 1'b1, 1'b0);
        check("c3_valid", 32'(o_valid), 32'd1);
        check("c3_data", 32'(o_data), 32'hC3);
        step(1'b0, 1'b0, 1'b1);
        check("c3_one_cycle", 32'(o_valid), 32'd0);

        // full frame then unlock; a sync-free byte afterwards yields nothing
        do_reset();
        send_sync(1'b1);
        for (int k = 0; k < 4; k++) begin
            send_byte(bytes4[k], 1'b1, 1'b0);
            check("frame_byte", 32'(o_data), 32'(bytes4[k]));
        end
        check("frame_unlock", 32'(o_locked), 32'd0);
        send_byte(8'hFF, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("frame_pulses", 32'(pulses), 32'd4);

        // overflow with stalled sink
        do_reset();
        send_sync(1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        check("ovf_hold_data", 32'(o_data), 32'hAA);
        check("ovf_set", 32'(o_overflow), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        check("ovf_drained", 32'(o_valid), 32'd0);
        check("ovf_sticky", 32'(o_overflow), 32'd1);

        // gapped enable
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(i[0], 1'b1, 1'b1);
            step(1'b1, 1'b0, 1'b1);
        end
        for (int i = 7; i >= 0; i--) begin
            step(c3[i], 1'b1, 1'b1);
            if (i != 0) step(~c3[i], 1'b0, 1'b1);
        end
        if (NB == 9) step(^c3, 1'b1, 1'b1);
        check("gap_data", 32'(o_data), 32'hC3);
        check("gap_valid", 32'(o_valid), 32'd1);

        // reset mid-frame with a held byte
        do_reset();
        send_sync(1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("mid_locked_before", 32'(o_locked), 32'd1);
        do_reset();
        send_sync(1'b1);
        send_byte(8'h5A, 1'b1, 1'b0);
        check("post_rst_data", 32'(o_data), 32'h5A);
        check("post_rst_valid", 32'(o_valid), 32'd1);

`ifdef SFR_FRAMER_PARITY_EN
        do_reset();
        send_sync(1'b1);
        send_byte(8'h03, 1'b1, 1'b0);
        check("par_ok", 32'(o_perr), 32'd0);
        send_byte(8'h07, 1'b1, 1'b1);
        check("par_bad", 32'(o_perr), 32'd1);
        check("par_bad_data", 32'(o_data), 32'h07);
`endif

        // randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
